// File: rtl/bf_addsub_unit.sv
// Post-multiplier butterfly add/sub stage for the unified Kyber/Dilithium NTT.
// Delays the operand `a` to meet the multiplier product `b_prod`, then
// produces u = (a + p) mod q and v = (a - p) mod q, optionally halved mod q.
// Kyber packs two independent 12-bit lanes; Dilithium uses one 23-bit lane.
module bf_addsub_unit #(
  parameter int ALIGN_DLY = 4,
  parameter int KQ        = 3329,
  parameter int DQ        = 8380417
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mode,
  input  logic        half_en,
  input  logic [23:0] a,
  input  logic [23:0] b_prod,
  output logic        out_valid,
  output logic [23:0] u,
  output logic [23:0] v
);

  localparam logic [23:0] KQ_W = 24'(KQ);
  localparam logic [23:0] DQ_W = 24'(DQ);
  localparam int          LW   = 27;  // {valid, mode, half_en, a}

  // Modular halving: an odd residue is made even by adding q before the shift.
  // 2q - 1 fits in 24 bits for both moduli, so no carry is lost.
  function automatic logic [23:0] halve(input logic [23:0] x, input logic [23:0] q);
    logic [23:0] t;
    if (x[0]) t = x + q;
    else      t = x;
    return {1'b0, t[23:1]};
  endfunction

  // Final sum: one conditional subtraction brings [0, 2q-2] into [0, q-1].
  function automatic logic [23:0] fin_sum(input logic [23:0] s, input logic [23:0] q,
                                          input logic h);
    logic [23:0] r;
    if (s >= q) r = s - q;
    else        r = s;
    if (h) r = halve(r, q);
    else   r = r;
    return r;
  endfunction

  // Final difference: d is two's complement; a negative value gets q added.
  function automatic logic [23:0] fin_dif(input logic [23:0] d, input logic [23:0] q,
                                          input logic h);
    logic [23:0] r;
    if (d[23]) r = d + q;
    else       r = d;
    if (h) r = halve(r, q);
    else   r = r;
    return r;
  endfunction

  // ------------------------------------------------------------------
  // Alignment line
  // ------------------------------------------------------------------
  logic [LW-1:0] line_r [ALIGN_DLY];
  logic [LW-1:0] tail_s;
  logic          tail_valid_s;
  logic          tail_mode_s;
  logic          tail_half_s;
  logic [23:0]   tail_a_s;

  // Free-running shift register carrying each sample's control and operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ALIGN_DLY; i++) line_r[i] <= '0;
    end else begin
      line_r[0] <= {in_valid, mode, half_en, a};
      for (int i = 1; i < ALIGN_DLY; i++) line_r[i] <= line_r[i-1];
    end
  end

  assign tail_s       = line_r[ALIGN_DLY-1];
  assign tail_valid_s = tail_s[26];
  assign tail_mode_s  = tail_s[25];
  assign tail_half_s  = tail_s[24];
  assign tail_a_s     = tail_s[23:0];

  // ------------------------------------------------------------------
  // Stage 1: raw sums and differences
  // ------------------------------------------------------------------
  logic [23:0] sum_lo_s, dif_lo_s;
  logic [12:0] sum_hi_s, dif_hi_s;

  // Raw add/subtract; the low lane doubles as the Dilithium lane.
  always_comb begin
    sum_lo_s = 24'd0;
    dif_lo_s = 24'd0;
    sum_hi_s = 13'd0;
    dif_hi_s = 13'd0;
    if (tail_mode_s) begin
      sum_lo_s = {1'b0, tail_a_s[22:0]} + {1'b0, b_prod[22:0]};
      dif_lo_s = {1'b0, tail_a_s[22:0]} - {1'b0, b_prod[22:0]};
    end else begin
      sum_lo_s = {12'd0, tail_a_s[11:0]} + {12'd0, b_prod[11:0]};
      dif_lo_s = {12'd0, tail_a_s[11:0]} - {12'd0, b_prod[11:0]};
      sum_hi_s = {1'b0, tail_a_s[23:12]} + {1'b0, b_prod[23:12]};
      dif_hi_s = {1'b0, tail_a_s[23:12]} - {1'b0, b_prod[23:12]};
    end
  end

  logic        p1_valid_r;
  logic        p1_mode_r;
  logic        p1_half_r;
  logic [23:0] p1_sum_lo_r, p1_dif_lo_r;
  logic [12:0] p1_sum_hi_r, p1_dif_hi_r;

  // Stage-1 register; data only loads when the tail carries a real sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_valid_r  <= 1'b0;
      p1_mode_r   <= 1'b0;
      p1_half_r   <= 1'b0;
      p1_sum_lo_r <= 24'd0;
      p1_dif_lo_r <= 24'd0;
      p1_sum_hi_r <= 13'd0;
      p1_dif_hi_r <= 13'd0;
    end else begin
      p1_valid_r <= tail_valid_s;
      if (tail_valid_s) begin
        p1_mode_r   <= tail_mode_s;
        p1_half_r   <= tail_half_s;
        p1_sum_lo_r <= sum_lo_s;
        p1_dif_lo_r <= dif_lo_s;
        p1_sum_hi_r <= sum_hi_s;
        p1_dif_hi_r <= dif_hi_s;
      end
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: modular correction, optional halving, output packing
  // ------------------------------------------------------------------
  logic [23:0] q_s;
  logic [22:0] u_lo_s, v_lo_s;
  logic [11:0] u_hi_s, v_hi_s;
  logic [23:0] u_nxt_s, v_nxt_s;

  // Correct both lanes and pack according to the sample's own mode.
  always_comb begin
    q_s    = p1_mode_r ? DQ_W : KQ_W;
    u_lo_s = 23'(fin_sum(p1_sum_lo_r, q_s, p1_half_r));
    v_lo_s = 23'(fin_dif(p1_dif_lo_r, q_s, p1_half_r));
    u_hi_s = 12'(fin_sum({11'd0, p1_sum_hi_r}, KQ_W, p1_half_r));
    v_hi_s = 12'(fin_dif({{11{p1_dif_hi_r[12]}}, p1_dif_hi_r}, KQ_W, p1_half_r));
    if (p1_mode_r) begin
      u_nxt_s = {1'b0, u_lo_s};
      v_nxt_s = {1'b0, v_lo_s};
    end else begin
      u_nxt_s = {u_hi_s, u_lo_s[11:0]};
      v_nxt_s = {v_hi_s, v_lo_s[11:0]};
    end
  end

  // Output register; results hold their last value between valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      u         <= 24'd0;
      v         <= 24'd0;
    end else begin
      out_valid <= p1_valid_r;
      if (p1_valid_r) begin
        u <= u_nxt_s;
        v <= v_nxt_s;
      end
    end
  end

endmodule

// File: tb/tb_bf_addsub_unit.sv
// Directed and randomized bench for bf_addsub_unit (ALIGN_DLY = 4).
module tb_bf_addsub_unit;

  localparam int KQ  = 3329;
  localparam int DQ  = 8380417;
  localparam int D   = 4;
  localparam int LAT = D + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        mode;
  logic        half_en;
  logic [23:0] a;
  logic [23:0] b_prod;
  logic        out_valid;
  logic [23:0] u;
  logic [23:0] v;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [23:0] sched  [int];
  logic [47:0] exp_at [int];

  always #5 clk = ~clk;

  bf_addsub_unit #(.ALIGN_DLY(D), .KQ(KQ), .DQ(DQ)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mode(mode), .half_en(half_en),
    .a(a), .b_prod(b_prod), .out_valid(out_valid), .u(u), .v(v)
  );

  // Advance one cycle; present the product scheduled for the new cycle, or junk.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sched.exists(cyc)) begin
      b_prod = sched[cyc];
      sched.delete(cyc);
    end else begin
      b_prod = 24'($urandom);
    end
  endtask

  task automatic send(input logic md, input logic he, input logic [23:0] av, input logic [23:0] pv);
    in_valid = 1'b1;
    mode     = md;
    half_en  = he;
    a        = av;
    sched[cyc + D] = pv;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    mode     = 1'($urandom);
    half_en  = 1'($urandom);
    a        = 24'($urandom);
  endtask

  // Send one sample and wait until its result is on the outputs.
  task automatic run_one(input logic md, input logic he, input logic [23:0] av, input logic [23:0] pv);
    send(md, he, av, pv);
    tick();
    idle();
    repeat (LAT - 1) tick();
  endtask

  function automatic longint lane_sum(input longint x, input longint y, input longint q, input logic he);
    longint r;
    r = (x + y) % q;
    if (he) r = (r * ((q + 1) / 2)) % q;
    return r;
  endfunction

  function automatic longint lane_dif(input longint x, input longint y, input longint q, input logic he);
    longint r;
    r = (x - y + q) % q;
    if (he) r = (r * ((q + 1) / 2)) % q;
    return r;
  endfunction

  function automatic logic [47:0] ref_uv(input logic md, input logic he, input logic [23:0] av, input logic [23:0] pv);
    logic [23:0] ru, rv;
    if (md) begin
      ru = {1'b0, 23'(lane_sum(av[22:0], pv[22:0], DQ, he))};
      rv = {1'b0, 23'(lane_dif(av[22:0], pv[22:0], DQ, he))};
    end else begin
      ru = {12'(lane_sum(av[23:12], pv[23:12], KQ, he)), 12'(lane_sum(av[11:0], pv[11:0], KQ, he))};
      rv = {12'(lane_dif(av[23:12], pv[23:12], KQ, he)), 12'(lane_dif(av[11:0], pv[11:0], KQ, he))};
    end
    return {ru, rv};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    send(1'b0, 1'b0, {12'd5, 12'd6}, {12'd7, 12'd8});
    tick();
    send(1'b1, 1'b0, 24'd1234, 24'd99);
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (u !== 24'd0) begin n_bad++; $display("FAIL reset_u: got %h expected 0", u); end
    n_cmp++; if (v !== 24'd0) begin n_bad++; $display("FAIL reset_v: got %h expected 0", v); end
    rst = 1'b0;
    idle();
    for (int k = 0; k < 10; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_drop k=%0d: got %b expected 0", k, out_valid); end
    end
  endtask

  task automatic test_kyber();
    run_one(1'b0, 1'b0, {12'd100, 12'd3000}, {12'd3328, 12'd500});
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL kyber_valid: got %b expected 1", out_valid); end
    n_cmp++; if (u !== {12'd99, 12'd171}) begin n_bad++; $display("FAIL kyber_u: got %h expected %h", u, {12'd99, 12'd171}); end
    n_cmp++; if (v !== {12'd101, 12'd2500}) begin n_bad++; $display("FAIL kyber_v: got %h expected %h", v, {12'd101, 12'd2500}); end
  endtask

  task automatic test_dilithium();
    run_one(1'b1, 1'b0, 24'd8380416, 24'd1);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL dil_valid: got %b expected 1", out_valid); end
    n_cmp++; if (u !== 24'd0) begin n_bad++; $display("FAIL dil_u: got %h expected 0", u); end
    n_cmp++; if (v !== 24'd8380415) begin n_bad++; $display("FAIL dil_v: got %0d expected 8380415", v); end
    run_one(1'b1, 1'b1, 24'd8380416, 24'd1);
    n_cmp++; if (u !== 24'd0) begin n_bad++; $display("FAIL dil_half_u: got %h expected 0", u); end
    n_cmp++; if (v !== 24'd8380416) begin n_bad++; $display("FAIL dil_half_v: got %0d expected 8380416", v); end
    run_one(1'b1, 1'b1, 24'd8380416 | 24'h800000, 24'd1);
    n_cmp++; if (u !== 24'd0) begin n_bad++; $display("FAIL dil_bit23_u: got %h expected 0", u); end
    n_cmp++; if (v !== 24'd8380416) begin n_bad++; $display("FAIL dil_bit23_v: got %h expected %h", v, 24'd8380416); end
  endtask

  task automatic test_kyber_half();
    run_one(1'b0, 1'b1, {12'd1, 12'd0}, {12'd0, 12'd0});
    n_cmp++; if (u !== {12'd1665, 12'd0}) begin n_bad++; $display("FAIL khalf_u: got %h expected %h", u, {12'd1665, 12'd0}); end
    n_cmp++; if (v !== {12'd1665, 12'd0}) begin n_bad++; $display("FAIL khalf_v: got %h expected %h", v, {12'd1665, 12'd0}); end
  endtask

  task automatic test_boundaries();
    // hi: 1000+2329 = q -> 0, 1000-2329 -> 2000; lo: 0+3328 -> 3328, 0-3328 -> 1
    run_one(1'b0, 1'b0, {12'd1000, 12'd0}, {12'd2329, 12'd3328});
    n_cmp++; if (u !== {12'd0, 12'd3328}) begin n_bad++; $display("FAIL bnd_k_u: got %h expected %h", u, {12'd0, 12'd3328}); end
    n_cmp++; if (v !== {12'd2000, 12'd1}) begin n_bad++; $display("FAIL bnd_k_v: got %h expected %h", v, {12'd2000, 12'd1}); end
    run_one(1'b1, 1'b0, 24'd12345, 24'd12345);
    n_cmp++; if (u !== 24'd24690) begin n_bad++; $display("FAIL bnd_eq_u: got %0d expected 24690", u); end
    n_cmp++; if (v !== 24'd0) begin n_bad++; $display("FAIL bnd_eq_v: got %0d expected 0", v); end
    run_one(1'b1, 1'b0, 24'd0, 24'd8380416);
    n_cmp++; if (u !== 24'd8380416) begin n_bad++; $display("FAIL bnd_zero_u: got %0d expected 8380416", u); end
    n_cmp++; if (v !== 24'd1) begin n_bad++; $display("FAIL bnd_zero_v: got %0d expected 1", v); end
  endtask

  task automatic test_latency();
    repeat (4) tick();
    send(1'b0, 1'b0, {12'd3, 12'd4}, {12'd5, 12'd6});
    for (int k = 1; k <= 10; k++) begin
      tick();
      idle();
      n_cmp++;
      if (out_valid !== (k == LAT)) begin
        n_bad++; $display("FAIL latency k=%0d: got %b expected %b", k, out_valid, (k == LAT));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        md [8];
    logic        he [8];
    logic [23:0] av [8];
    logic [23:0] pv [8];
    logic [47:0] e;
    for (int k = 0; k < 8; k++) begin
      md[k] = k[0];
      he[k] = k[1];
      if (k[0]) begin
        av[k] = 24'(DQ - 1 - k * 1000003);
        pv[k] = 24'(k * 777777 + 5);
      end else begin
        av[k] = {12'(100 * k + 7), 12'(3328 - k * 200)};
        pv[k] = {12'(3000 - k * 11), 12'(k * 300 + 1)};
      end
    end
    for (int k = 0; k < 16; k++) begin
      if (k < 8) send(md[k], he[k], av[k], pv[k]);
      else       idle();
      tick();
      if (k + 1 - LAT >= 0 && k + 1 - LAT < 8) begin
        e = ref_uv(md[k+1-LAT], he[k+1-LAT], av[k+1-LAT], pv[k+1-LAT]);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid s=%0d: got %b expected 1", k + 1 - LAT, out_valid); end
        n_cmp++; if (u !== e[47:24]) begin n_bad++; $display("FAIL b2b_u s=%0d: got %h expected %h", k + 1 - LAT, u, e[47:24]); end
        n_cmp++; if (v !== e[23:0]) begin n_bad++; $display("FAIL b2b_v s=%0d: got %h expected %h", k + 1 - LAT, v, e[23:0]); end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle k=%0d: got %b expected 0", k, out_valid); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [47:0] e;
    e = ref_uv(1'b0, 1'b0, {12'd2000, 12'd50}, {12'd1500, 12'd60});
    for (int k = 0; k < 13; k++) begin
      if (k < 3)       send(1'b1, 1'b0, 24'(1000 * k + 1), 24'd2);
      else if (k == 3) send(1'b0, 1'b0, {12'd2000, 12'd50}, {12'd1500, 12'd60});
      else             idle();
      rst = (k == 2);
      tick();
      if (k + 1 == 3) begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
        n_cmp++; if (u !== 24'd0) begin n_bad++; $display("FAIL rmid_u0: got %h expected 0", u); end
        n_cmp++; if (v !== 24'd0) begin n_bad++; $display("FAIL rmid_v0: got %h expected 0", v); end
      end else begin
        n_cmp++;
        if (out_valid !== (k + 1 == 9)) begin
          n_bad++; $display("FAIL rmid_out t=%0d: got %b expected %b", k + 1, out_valid, (k + 1 == 9));
        end
      end
      if (k + 1 == 9) begin
        n_cmp++; if (u !== e[47:24]) begin n_bad++; $display("FAIL rmid_u: got %h expected %h", u, e[47:24]); end
        n_cmp++; if (v !== e[23:0]) begin n_bad++; $display("FAIL rmid_v: got %h expected %h", v, e[23:0]); end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic        md, he;
    logic [23:0] av, pv;
    logic [47:0] e;
    int          sent;
    sent = 0;
    for (int k = 0; k < 10100; k++) begin
      if (sent < 10000 && $urandom_range(0, 7) != 0) begin
        md = 1'($urandom);
        he = 1'($urandom);
        if (md) begin
          av = {1'($urandom), 23'($urandom_range(0, DQ - 1))};
          pv = {1'b0, 23'($urandom_range(0, DQ - 1))};
        end else begin
          av = {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
          pv = {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
        end
        send(md, he, av, pv);
        exp_at[cyc + LAT] = ref_uv(md, he, av, pv);
        sent++;
      end else begin
        idle();
      end
      tick();
      if (exp_at.exists(cyc)) begin
        e = exp_at[cyc];
        exp_at.delete(cyc);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rnd_valid c=%0d: got %b expected 1", cyc, out_valid); end
        n_cmp++; if (u !== e[47:24]) begin n_bad++; $display("FAIL rnd_u c=%0d: got %h expected %h", cyc, u, e[47:24]); end
        n_cmp++; if (v !== e[23:0]) begin n_bad++; $display("FAIL rnd_v c=%0d: got %h expected %h", cyc, v, e[23:0]); end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_idle c=%0d: got %b expected 0", cyc, out_valid); end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    mode     = 1'b0;
    half_en  = 1'b0;
    a        = 24'd0;
    b_prod   = 24'd0;
    test_reset();
    test_kyber();
    test_dilithium();
    test_kyber_half();
    test_boundaries();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bf_addsub_unit.md
# bf_addsub_unit

Post-multiplier butterfly add/sub stage for the unified Kyber/Dilithium NTT datapath. It sits directly downstream of the dual-mode modular multiplier. For each sample it takes the reduced product `p` from the multiplier and the other butterfly operand `a`, which it delays internally to line up with `p`. It then produces `u = (a + p) mod q` and `v = (a − p) mod q`, with an optional modular halving used for INTT scaling. Kyber mode runs two packed 12-bit lanes; Dilithium mode runs one 23-bit lane.

## Interface
Parameters:
- `ALIGN_DLY`, default 4: cycles between a sample's `in_valid` and the arrival of its product on `b_prod`. Must be ≥ 1.
- `KQ`, default 3329: Kyber modulus.
- `DQ`, default 8380417: Dilithium modulus.

Ports:
- `clk`  in  1  clock. One clock domain only.
- `rst`  in  1  reset. Synchronous, active-high.
- `in_valid`  in  1  `a`, `mode` and `half_en` are valid this cycle.
- `mode`  in  1  0 = Kyber (two 12-bit lanes), 1 = Dilithium (one 23-bit lane).
- `half_en`  in  1  1 = multiply both outputs by 2⁻¹ mod q.
- `a`  in  24  butterfly operand. Kyber: `{hi[23:12], lo[11:0]}`. Dilithium: `[22:0]`, with bit 23 ignored.
- `b_prod`  in  24  multiplier result, same packing as `a`. Sampled exactly `ALIGN_DLY` cycles after the matching `in_valid`.
- `out_valid`  out  1  `u` and `v` are valid this cycle.
- `u`  out  24  sum output, same packing. Dilithium bit 23 = 0.
- `v`  out  24  difference output, same packing. Dilithium bit 23 = 0.

## Operation
- Alignment line:
  - An `ALIGN_DLY`-deep shift register carries `{in_valid, mode, half_en, a}`, advancing every cycle.
  - The line has no stall or backpressure; one sample per cycle is accepted.
  - `mode` and `half_en` travel with each sample, so mixed-mode streams are legal back to back.
- Stage 1 (registered), at the tail of the line, combined with `b_prod`:
  - Kyber, per lane independently: `s = a_l + p_l` (13 bit), `d = a_l − p_l` (signed 13 bit).
  - Dilithium: `s = a[22:0] + p[22:0]` (24 bit), `d = a − p` (signed 24 bit).
- Stage 2 (registered, drives the outputs):
  - Sum correction: if `s ≥ q`, then `s −= q`.
  - Difference correction: if `d < 0`, then `d += q`.
  - If `half_en`, apply to each corrected value x: `x` even → `x >> 1`; `x` odd → `(x + q) >> 1`.
  - Result ranges: `[0, q−1]` per lane (Kyber) or for the single lane (Dilithium).
- Input range:
  - Operands must be in `[0, q−1]`.
  - Operands ≥ q give unspecified values but must not corrupt valid flags or adjacent samples.
- When `out_valid = 0`, `u` and `v` hold their last value.

## Timing
- Latency: a sample accepted at cycle t appears with `out_valid = 1` at cycle `t + ALIGN_DLY + 2`.
- Throughput: 1 sample per cycle.
- Reset:
  - While `rst` is high: all valid bits in the line and stages clear; `out_valid = 0`, `u = 0`, `v = 0`; the data fields of the line clear to 0.
  - Any sample accepted in or before the reset cycle never emerges.
  - A sample accepted in the first cycle after `rst` deasserts emerges normally.
- `b_prod` is ignored in cycles where the tail valid bit is 0.
- Simultaneous `in_valid` and `rst`: reset wins; the sample is dropped.
- Boundary sums and differences:
  - `a + p = q` → 0.
  - `a = p` → `v = 0`.
  - `a = 0`, `p = q − 1` → `v = 1`.

## Test plan
- Kyber, `half_en = 0`: `a = {100, 3000}`, `p = {3328, 500}` → `u = {99, 171}`, `v = {101, 2500}`.
- Dilithium, `half_en = 0`: `a = 8380416`, `p = 1` → `u = 0`, `v = 8380415`. Repeat with `half_en = 1` → `u = 0`, `v = 8380416`. Repeat with `a[23] = 1` → identical outputs, and bit 23 of both outputs is 0.
- Kyber halving: `a = {1, 0}`, `p = {0, 0}`, `half_en = 1` → `u = {1665, 0}`, `v = {1665, 0}`.
- Latency and streaming, `ALIGN_DLY = 4`:
  - A single `in_valid` pulse at cycle 10 → `out_valid` high only at cycle 16.
  - 8 back-to-back samples with alternating modes → 8 consecutive `out_valid` cycles; all results match a reference model.
- Reset mid-operation: `in_valid` high in cycles 0–3, `rst` high in cycle 2 only → `out_valid` only at cycle 9, for the sample from cycle 3; `u = v = 0` during reset.
- Randomized: 10k mixed-mode, random-`half_en` samples with in-range operands → exact match against a modular reference.
